// File: rtl/ntt_sequencer_if.sv
// Control handshake and memory-port signals between the NTT sequencer and its host/datapath.
// The sequencer connects through the master modport; the host/datapath side uses slave.
interface ntt_sequencer_if #(
    parameter int LOG_N = 8
);
    logic             start;
    logic             is_ntt;
    logic             abort;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-2:0] tw_addr;
    logic             scale_en;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
    logic [3:0]       stage;

    modport master (
        input  start, is_ntt, abort,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, scale_en,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start, is_ntt, abort,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, scale_en,
               wr_en, wr_addr_a, wr_addr_b, stage
    );
endinterface

// File: rtl/ntt_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 NTT/INTT: issues butterfly reads per pass and
// replays them as writes PIPE cycles later.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one read per cycle for the current pass
// DRAIN  | reads stopped, waiting for the pass's last write to leave the delay line
// FINISH | one-cycle done pulse
module ntt_sequencer #(
    parameter int LOG_N  = 8,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ntt_sequencer_if.master bus
);
    localparam int PIPE = RD_LAT + BF_LAT;
    localparam int HALF = 1 << (LOG_N - 1);
    localparam int S    = LOG_N - 1;
    localparam int AW   = LOG_N;
    localparam int PW   = LOG_N - 1;
    localparam int CW   = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t        state, state_nx;
    logic [3:0]    pass_q, pass_nx;
    logic [PW-1:0] pair_q, pair_nx;
    logic [CW-1:0] drain_q, drain_nx;
    logic          inv_q, inv_nx;
    logic          last_pass, last_pair, kill;

    logic          rd_en_d, scale_d;
    logic [AW-1:0] addr_a_d, addr_b_d;
    logic [PW-1:0] tw_d;
    logic [3:0]    stage_d;
    logic [3:0]    lg;
    logic [AW-1:0] p_ext, len, grp;

    logic          rd_en_q, scale_q;
    logic [AW-1:0] addr_a_q, addr_b_q;
    logic [PW-1:0] tw_q;
    logic [3:0]    stage_q;

    logic [PIPE-1:0]         dl_vld;
    logic [PIPE-1:0][AW-1:0] dl_a, dl_b;

    assign last_pass = (pass_q == (inv_q ? 4'(S) : 4'(S - 1)));
    assign last_pair = (pair_q == PW'(HALF - 1));
    assign kill      = bus.abort && ((state == RUN) || (state == DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pass_q   <= '0;
            pair_q   <= '0;
            drain_q  <= '0;
            inv_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            scale_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
        end else begin
            state    <= state_nx;
            pass_q   <= pass_nx;
            pair_q   <= pair_nx;
            drain_q  <= drain_nx;
            inv_q    <= inv_nx;
            rd_en_q  <= rd_en_d;
            scale_q  <= scale_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
        end
    end

    always_comb begin
        state_nx = state;
        pass_nx  = pass_q;
        pair_nx  = pair_q;
        drain_nx = drain_q;
        inv_nx   = inv_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    pass_nx  = '0;
                    pair_nx  = '0;
                    inv_nx   = !bus.is_ntt;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (last_pair) begin
                    state_nx = DRAIN;
                    drain_nx = CW'(PIPE - 1);
                end else begin
                    pair_nx = pair_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (drain_q == '0) begin
                    if (last_pass) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = RUN;
                        pass_nx  = pass_q + 4'd1;
                        pair_nx  = '0;
                    end
                end else begin
                    drain_nx = drain_q - 1'b1;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read-side outputs are computed from next-cycle state so they can be registered.
    // lg = log2(len); groups of len pairs map to blocks of 2*len words.
    always_comb begin
        rd_en_d  = (state_nx == RUN);
        scale_d  = 1'b0;
        addr_a_d = '0;
        addr_b_d = '0;
        tw_d     = '0;
        stage_d  = '0;
        p_ext    = {1'b0, pair_nx};
        lg       = inv_nx ? (pass_nx + 4'd1) : (4'(LOG_N - 1) - pass_nx);
        len      = AW'(1) << lg;
        grp      = p_ext >> lg;
        if (rd_en_d) begin
            stage_d = pass_nx;
            if (inv_nx && (pass_nx == 4'(S))) begin
                scale_d  = 1'b1;
                addr_a_d = p_ext;
                addr_b_d = p_ext + AW'(HALF);
            end else begin
                addr_a_d = ((grp << lg) << 1) | (p_ext & (len - AW'(1)));
                addr_b_d = addr_a_d + len;
                tw_d     = inv_nx ? PW'((AW'(HALF) >> pass_nx) - AW'(1) - grp)
                                  : PW'((AW'(1) << pass_nx) + grp);
            end
        end
    end

    // Delay line mirrors the memory read + butterfly latency; abort flushes in-flight writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
            dl_a   <= '0;
            dl_b   <= '0;
        end else if (kill) begin
            dl_vld <= '0;
            dl_a   <= '0;
            dl_b   <= '0;
        end else if (PIPE > 1) begin
            dl_vld <= {dl_vld[PIPE-2:0], rd_en_q};
            dl_a   <= {dl_a[PIPE-2:0], addr_a_q};
            dl_b   <= {dl_b[PIPE-2:0], addr_b_q};
        end else begin
            dl_vld <= PIPE'(rd_en_q);
            dl_a   <= (PIPE * AW)'(addr_a_q);
            dl_b   <= (PIPE * AW)'(addr_b_q);
        end
    end

    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == FINISH);
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = addr_a_q;
    assign bus.rd_addr_b = addr_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.scale_en  = scale_q;
    assign bus.stage     = stage_q;
    assign bus.wr_en     = dl_vld[PIPE-1];
    assign bus.wr_addr_a = dl_a[PIPE-1];
    assign bus.wr_addr_b = dl_b[PIPE-1];
endmodule

// File: tb/tb_ntt_sequencer.sv
// Scoreboard bench for ntt_sequencer: two configurations, stimulus pushes expected reads/writes/done,
// a negedge monitor pops and compares them cycle by cycle.
module tb_ntt_sequencer;
    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int sc;
        int st;
    } rd_t;

    typedef struct {
        int cyc;
        int a;
        int b;
    } wr_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   wr_cnt [2];
    int   last_done [2];
    rd_t  exp_rd [2][$];
    wr_t  exp_wr [2][$];
    int   exp_done [2][$];
    int   base;

    ntt_sequencer_if #(.LOG_N(8)) bus0 ();
    ntt_sequencer_if #(.LOG_N(4)) bus1 ();

    ntt_sequencer #(.LOG_N(8), .RD_LAT(1), .BF_LAT(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    ntt_sequencer #(.LOG_N(4), .RD_LAT(2), .BF_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sequence straight from the pass/pair formulas (division/modulo form).
    task automatic push_xfer(input int id, input int log_n, input int pipe, input bit inv, input int b0);
        int  n, h, s_cnt, passes, len, g;
        rd_t r;
        wr_t w;
        n      = 1 << log_n;
        h      = n / 2;
        s_cnt  = log_n - 1;
        passes = s_cnt + (inv ? 1 : 0);
        for (int s = 0; s < passes; s++) begin
            for (int p = 0; p < h; p++) begin
                r.cyc = b0 + 1 + s * (h + pipe) + p;
                r.st  = s;
                if (inv && s == s_cnt) begin
                    r.a  = p;
                    r.b  = p + h;
                    r.tw = 0;
                    r.sc = 1;
                end else begin
                    len  = inv ? (2 << s) : (n >> (s + 1));
                    g    = p / len;
                    r.a  = 2 * len * g + p % len;
                    r.b  = r.a + len;
                    r.tw = inv ? (n / len - 1 - g) : ((1 << s) + g);
                    r.sc = 0;
                end
                exp_rd[id].push_back(r);
                w.cyc = r.cyc + pipe;
                w.a   = r.a;
                w.b   = r.b;
                exp_wr[id].push_back(w);
            end
        end
        exp_done[id].push_back(b0 + passes * (h + pipe) + 1);
    endtask

    task automatic truncate(input int id, input int lim);
        while (exp_rd[id].size() > 0 && exp_rd[id][exp_rd[id].size()-1].cyc > lim)
            void'(exp_rd[id].pop_back());
        while (exp_wr[id].size() > 0 && exp_wr[id][exp_wr[id].size()-1].cyc > lim)
            void'(exp_wr[id].pop_back());
        exp_done[id].delete();
    endtask

    task automatic start_xfer(input int id, input bit inv, output int b0);
        b0 = cyc;
        wr_cnt[id]    = 0;
        last_done[id] = -1;
        if (id == 0) push_xfer(0, 8, 5, inv, b0);
        else         push_xfer(1, 4, 3, inv, b0);
        if (id == 0) begin
            bus0.start  = 1'b1;
            bus0.is_ntt = !inv;
        end else begin
            bus1.start  = 1'b1;
            bus1.is_ntt = !inv;
        end
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_quiet(input int id, input int budget);
        int k;
        k = 0;
        while ((exp_rd[id].size() + exp_wr[id].size() + exp_done[id].size()) > 0 && k < budget) begin
            tick();
            k++;
        end
        check_int("drain_within_budget", int'(k < budget), 1);
        repeat (8) tick();
    endtask

    task automatic mon(input int id, input logic rd_en, input int a, input int b, input int tw,
                       input logic sc, input int st, input logic wr_en, input int wa, input int wb,
                       input logic done);
        bit  exp_now;
        rd_t r;
        wr_t w;
        exp_now = (exp_rd[id].size() > 0) && (exp_rd[id][0].cyc == cyc);
        check_int("rd_en", int'(rd_en), int'(exp_now));
        if (exp_now) begin
            r = exp_rd[id].pop_front();
            if (rd_en) begin
                check_int("rd_addr_a", a, r.a);
                check_int("rd_addr_b", b, r.b);
                check_int("tw_addr", tw, r.tw);
                check_int("scale_en", int'(sc), r.sc);
                check_int("stage", st, r.st);
            end
        end else if (!rd_en) begin
            check_int("rd_addr_idle_zero", a | b | tw, 0);
        end

        exp_now = (exp_wr[id].size() > 0) && (exp_wr[id][0].cyc == cyc);
        check_int("wr_en", int'(wr_en), int'(exp_now));
        if (wr_en) wr_cnt[id]++;
        if (exp_now) begin
            w = exp_wr[id].pop_front();
            if (wr_en) begin
                check_int("wr_addr_a", wa, w.a);
                check_int("wr_addr_b", wb, w.b);
            end
        end

        exp_now = (exp_done[id].size() > 0) && (exp_done[id][0] == cyc);
        check_int("done", int'(done), int'(exp_now));
        if (done) last_done[id] = cyc;
        if (exp_now) void'(exp_done[id].pop_front());
    endtask

    always @(negedge clk) begin
        mon(0, bus0.rd_en, int'(bus0.rd_addr_a), int'(bus0.rd_addr_b), int'(bus0.tw_addr),
            bus0.scale_en, int'(bus0.stage), bus0.wr_en, int'(bus0.wr_addr_a),
            int'(bus0.wr_addr_b), bus0.done);
        mon(1, bus1.rd_en, int'(bus1.rd_addr_a), int'(bus1.rd_addr_b), int'(bus1.tw_addr),
            bus1.scale_en, int'(bus1.stage), bus1.wr_en, int'(bus1.wr_addr_a),
            int'(bus1.wr_addr_b), bus1.done);
    end

    task automatic check_all_zero(input string nm);
        check_int({nm, "_busy"}, int'(bus0.busy), 0);
        check_int({nm, "_done"}, int'(bus0.done), 0);
        check_int({nm, "_rd_en"}, int'(bus0.rd_en), 0);
        check_int({nm, "_wr_en"}, int'(bus0.wr_en), 0);
        check_int({nm, "_scale_en"}, int'(bus0.scale_en), 0);
        check_int({nm, "_stage"}, int'(bus0.stage), 0);
        check_int({nm, "_addrs"}, int'(bus0.rd_addr_a | bus0.rd_addr_b | bus0.wr_addr_a | bus0.wr_addr_b), 0);
        check_int({nm, "_tw"}, int'(bus0.tw_addr), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i]    = 0;
            last_done[i] = -1;
        end
        rst_n       = 1'b0;
        bus0.start  = 1'b0;
        bus0.is_ntt = 1'b1;
        bus0.abort  = 1'b0;
        bus1.start  = 1'b0;
        bus1.is_ntt = 1'b1;
        bus1.abort  = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        check_int("reset_dut1_busy", int'(bus1.busy), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // abort while idle does nothing
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        check_int("idle_abort_busy", int'(bus0.busy), 0);
        repeat (2) tick();

        // forward NTT; a second start and an is_ntt flip mid-run must be ignored
        start_xfer(0, 1'b0, base);
        check_int("ntt_busy_after_start", int'(bus0.busy), 1);
        wait_cyc(base + 50);
        bus0.start  = 1'b1;
        bus0.is_ntt = 1'b0;
        tick();
        bus0.start = 1'b0;
        wait_quiet(0, 2000);
        check_int("ntt_done_latency", last_done[0] - base, 932);
        check_int("ntt_wr_count", wr_cnt[0], 896);
        check_int("ntt_busy_end", int'(bus0.busy), 0);

        // inverse NTT with scaling pass
        start_xfer(0, 1'b1, base);
        wait_quiet(0, 2000);
        check_int("intt_done_latency", last_done[0] - base, 1065);
        check_int("intt_wr_count", wr_cnt[0], 1024);

        // abort mid-transform
        start_xfer(0, 1'b0, base);
        wait_cyc(base + 300);
        bus0.abort = 1'b1;
        truncate(0, base + 300);
        tick();
        bus0.abort = 1'b0;
        check_int("abort_busy_cleared", int'(bus0.busy), 0);
        repeat (20) tick();
        check_int("abort_no_done", last_done[0], -1);
        check_int("abort_wr_count", wr_cnt[0], 285);

        // reset mid-transform, then restart with start and abort both high
        start_xfer(0, 1'b0, base);
        wait_cyc(base + 400);
        check_int("pre_reset_stage", int'(bus0.stage), 3);
        rst_n = 1'b0;
        truncate(0, base + 399);
        #1;
        check_all_zero("async_reset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check_int("post_reset_no_done", last_done[0], -1);
        bus0.abort = 1'b1;
        start_xfer(0, 1'b0, base);
        bus0.abort = 1'b0;
        check_int("start_beats_abort_busy", int'(bus0.busy), 1);
        wait_quiet(0, 2000);
        check_int("restart_done_latency", last_done[0] - base, 932);
        check_int("restart_wr_count", wr_cnt[0], 896);

        // small configuration: LOG_N=4, PIPE=3
        start_xfer(1, 1'b0, base);
        wait_quiet(1, 200);
        check_int("small_ntt_done_latency", last_done[1] - base, 34);
        check_int("small_ntt_wr_count", wr_cnt[1], 24);
        start_xfer(1, 1'b1, base);
        wait_quiet(1, 200);
        check_int("small_intt_done_latency", last_done[1] - base, 45);
        check_int("small_intt_wr_count", wr_cnt[1], 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_sequencer.md
NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of the polynomial length N (legal range 4..12).
REQ-002 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles (legal range 1..4).
REQ-003 SHALL have parameter BF_LAT, default 4, meaning butterfly pipeline latency in cycles (legal range 1..16); PIPE = RD_LAT + BF_LAT.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a transform; sampled only in IDLE.
REQ-007 is_ntt  input  1  1 = forward NTT, 0 = inverse NTT; latched when start is accepted.
REQ-008 abort  input  1  synchronous cancel of a running transform.
REQ-009 busy  output  1  high while a transform is in progress.
REQ-010 done  output  1  one-cycle pulse when a transform completes.
REQ-011 rd_en  output  1  read strobe for both memory ports.
REQ-012 rd_addr_a / rd_addr_b  output  LOG_N each  read addresses j and j+len.
REQ-013 tw_addr  output  LOG_N-1  twiddle ROM address, valid with rd_en.
REQ-014 scale_en  output  1  high with rd_en during the INTT scaling pass.
REQ-015 wr_en  output  1  write strobe for both memory ports.
REQ-016 wr_addr_a / wr_addr_b  output  LOG_N each  write addresses.
REQ-017 stage  output  4  index of the pass currently being read.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN and FINISH.
- IDLE->RUN on start; RUN->DRAIN after the last read of a pass; DRAIN->RUN (next pass) after the last write of the pass; DRAIN->FINISH after the last write of the final pass; FINISH->IDLE after one cycle.
REQ-019 SHALL use S = LOG_N-1 butterfly passes, plus one scaling pass when is_ntt=0.
REQ-020 Each pass SHALL issue exactly N/2 reads on consecutive cycles, with pair index p = 0..N/2-1.
REQ-021 NTT pass s SHALL use len = N>>(s+1), g = p/len, a = 2·len·g + p%len, b = a+len, tw_addr = 2^s + g.
REQ-022 INTT pass s SHALL use len = 2<<s, g = p/len, a and b as in REQ-021, tw_addr = N/len - 1 - g.
REQ-023 The INTT scaling pass SHALL use a = p, b = p + N/2, tw_addr = 0, scale_en = 1; stage = S.
REQ-024 A read issued in cycle c SHALL produce wr_en in cycle c+PIPE, with the same a/b addresses, through a PIPE-deep delay line of valid and address entries.
REQ-025 The next pass SHALL issue its first read in the cycle after the previous pass's last write, with rd_en = 0 for PIPE cycles between passes (no read-after-write hazard).
REQ-026 Start accepted at edge t SHALL give busy = 1 and the first rd_en in cycle t+1.
REQ-027 done SHALL pulse in the cycle after the final write; busy SHALL deassert in that same cycle.
REQ-028 Total latency from the start edge to done SHALL be (S + !is_ntt)·(N/2 + PIPE) + 1 cycles.
REQ-029 start while busy SHALL be ignored, and is_ntt changes while busy SHALL have no effect.
REQ-030 abort in RUN/DRAIN SHALL, at the next edge: return the FSM to IDLE, clear busy, clear all delay-line valid bits (no further wr_en), and produce no done.
REQ-031 abort in IDLE SHALL be ignored; if start and abort are both high in IDLE, start SHALL win.
REQ-032 rd_en, all addresses, scale_en and stage SHALL be registered outputs; addresses SHALL be 0 whenever rd_en = 0.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE; busy, done, rd_en, wr_en, scale_en = 0; all addresses = 0; stage = 0; delay line cleared.
REQ-034 Reset asserted mid-transform SHALL produce no further wr_en or done after release until a new start.

Verification
REQ-035 LOG_N=8, PIPE=5, NTT start at t -> first read (a=0, b=128, tw=1) at t+1; pass 1 first read (0, 64, tw=2) at t+134; done at t+932; exactly 896 wr_en cycles.
REQ-036 Same configuration, INTT -> pass 0 first read (0, 2, tw=127); scaling pass reads (0, 128) with scale_en at t+932; done at t+1065; 1024 wr_en cycles.
REQ-037 Every write -> wr_addr equals the rd_addr issued exactly PIPE cycles earlier; the rd_en gap between passes is exactly 5 cycles.
REQ-038 start pulsed at t+50 of a running NTT -> ignored, single done at t+932; abort at t+300 -> busy = 0 at t+301, no wr_en or done afterwards.
REQ-039 rst_n low at t+400 -> all outputs 0 immediately; new start after release -> full correct sequence with done at the nominal latency.
REQ-040 LOG_N=4, RD_LAT=2, BF_LAT=1, NTT -> 3 passes of 8 reads, PIPE = 3, done at t+34; address and twiddle sequence matches the REQ-021 formulas.
